vga_timing_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator.
- Samples the active-low `hsync_i`/`vsync_i` and 4:4:4 RGB pins at one pixel per `SYS_CLK`, locks to 640x480 timing and recovers `row_o`/`column_o` for each visible pixel.
- Flags timing violations and produces a per-frame pixel checksum.
- Used in loopback self-test and simulation benches to check the sprite/game video output.

---
 rtl/vga_timing_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Receive-side counterpart of the VGA timing generator. Samples the sync and
// RGB pins one pixel per SYS_CLK and locks to the incoming raster. Once locked,
// it recovers row/column for every visible pixel. It flags sync, line and
// frame timing violations with sticky bits, and it produces a 16-bit checksum
// of every frame that was received entirely in lock.

module vga_timing_decoder #(
  parameter int H_VISIBLE = 640,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic        SYS_CLK,
  input  logic        reset,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic        pix_valid_o,
  output logic [11:0] rgb_o,
  output logic [8:0]  row_o,
  output logic [9:0]  column_o,
  output logic        locked_o,
  output logic        frame_done_o,
  output logic [15:0] frame_sum_o,
  output logic        err_hsync_o,
  output logic        err_line_o,
  output logic        err_frame_o
);

  // Counter limits. The pixel counter saturates instead of wrapping, so a
  // missing hsync is never mistaken for a legal line.
  localparam logic [10:0] P_MAX      = 11'h7FF;
  localparam logic [9:0]  V_MAX      = 10'h3FF;

  // Raster landmarks, expressed in counter units.
  localparam logic [10:0] H_START    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END      = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] H_SYNC_LEN = 11'(H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_START    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END      = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Input stage: S1 holds the pins, S2 holds the previous sync levels.
  logic        hs1_q, vs1_q, hs2_q, vs2_q;
  logic [11:0] rgb1_q;

  // Raster position of the pixel currently held in S1.
  logic [10:0] p_q, p_d;
  logic [9:0]  v_q, v_d;
  logic        vfall_pend_q, vfall_pend_d;

  // Edge strobes and checks, all derived from S1/S2.
  logic        hs_fall, hs_rise, vs_fall;
  logic        v_restart;
  logic        viol_h, viol_l, viol_f, viol_any;
  logic        visible;
  logic        pix_valid_d;
  logic [8:0]  row_d;
  logic [9:0]  col_d;

  // Lock FSM and registered outputs.
  state_e      state_q;
  logic        locked_q;
  logic        pix_valid_q;
  logic [11:0] rgb_q;
  logic [8:0]  row_q;
  logic [9:0]  col_q;
  logic        frame_done_q;
  logic [15:0] frame_sum_q;
  logic [15:0] acc_q;
  logic        err_hsync_q, err_line_q, err_frame_q;

  // Register the pins once (S1), then keep one more copy of the syncs (S2).
  always_ff @(posedge SYS_CLK) begin
    // NOTE: every clocked block uses non-blocking assignments, so the S1->S2
    // copy sees the old S1 value and the order of statements does not matter.
    if (reset) begin
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      rgb1_q <= '0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      hs1_q  <= hsync_i;
      vs1_q  <= vsync_i;
      rgb1_q <= {red_i, green_i, blue_i};
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  // Edge detection, raster counters, violation checks and visibility decode.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    hs_fall      = hs2_q & ~hs1_q;
    hs_rise      = ~hs2_q & hs1_q;
    vs_fall      = vs2_q & ~vs1_q;

    p_d          = (p_q == P_MAX) ? P_MAX : p_q + 11'd1;
    v_d          = v_q;
    v_restart    = 1'b0;
    vfall_pend_d = vfall_pend_q | vs_fall;

    if (hs_fall) begin
      p_d          = '0;
      // A vsync fall anywhere since the last line start (this cycle included)
      // makes this line the first line of a new frame.
      v_restart    = vfall_pend_q | vs_fall;
      v_d          = v_restart ? '0 : ((v_q == V_MAX) ? V_MAX : v_q + 10'd1);
      vfall_pend_d = 1'b0;
    end

    // The hsync must stay low for exactly H_SYNC clocks.
    viol_h   = hs_rise & (p_d != H_SYNC_LEN);
    // A line must be H_TOTAL clocks long. A lost hsync is caught when the
    // counter hits saturation.
    viol_l   = (hs_fall & (p_q != H_LAST)) |
               (~hs_fall & (p_q == P_MAX - 11'd1));
    // A frame must be V_TOTAL lines long, measured at the line that restarts v.
    viol_f   = v_restart & (v_q != V_LAST);
    viol_any = viol_h | viol_l | viol_f;

    visible  = (p_d >= H_START) && (p_d < H_END) &&
               (v_d >= V_START) && (v_d < V_END);

    // A violation drops pixel output on the same edge that leaves LOCKED.
    pix_valid_d = visible & (state_q == ST_LOCKED) & ~viol_any;
    row_d       = 9'(v_d - V_START);
    col_d       = 10'(p_d - H_START);
  end

  // Advance the raster counters.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      p_q          <= '0;
      v_q          <= '0;
      vfall_pend_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      v_q          <= v_d;
      vfall_pend_q <= vfall_pend_d;
    end
  end

  // Lock FSM with registered pixel, checksum and error outputs.
  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      locked_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      rgb_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= '0;
      acc_q        <= '0;
      err_hsync_q  <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      // Pixel data is forced to zero whenever it is not qualified.
      pix_valid_q  <= pix_valid_d;
      rgb_q        <= pix_valid_d ? rgb1_q : '0;
      row_q        <= pix_valid_d ? row_d  : '0;
      col_q        <= pix_valid_d ? col_d  : '0;
      frame_done_q <= 1'b0;

      // The accumulator restarts on every vsync fall and wraps modulo 2^16.
      if (vs_fall) begin
        acc_q <= '0;
      end else if (pix_valid_q) begin
        acc_q <= acc_q + {4'd0, rgb_q};
      end

      unique case (state_q)
        ST_HUNT: begin
          if (vs_fall) begin
            state_q <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          // One full clean frame is needed before lock is declared. A
          // violation wins over a simultaneous vsync fall.
          if (viol_any) begin
            state_q <= ST_HUNT;
          end else if (vs_fall) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (viol_any) begin
            state_q     <= ST_HUNT;
            locked_q    <= 1'b0;
            err_hsync_q <= err_hsync_q | viol_h;
            err_line_q  <= err_line_q  | viol_l;
            err_frame_q <= err_frame_q | viol_f;
          end else if (vs_fall) begin
            // LOCKED is only entered on a vsync fall, so a fall seen here
            // closes a frame that was received entirely in lock.
            frame_sum_q  <= acc_q;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid_o  = pix_valid_q;
  assign rgb_o        = rgb_q;
  assign row_o        = row_q;
  assign column_o     = col_q;
  assign locked_o     = locked_q;
  assign frame_done_o = frame_done_q;
  assign frame_sum_o  = frame_sum_q;
  assign err_hsync_o  = err_hsync_q;
  assign err_line_o   = err_line_q;
  assign err_frame_o  = err_frame_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder. It uses a shrunken raster (20x12
// clocks per frame, 8x4 visible) so that many frames fit in a short run.
// Expected values are computed by hand for that raster:
//   constant 0xFFF frame   : 32 * 0xFFF        mod 2^16 = 0xFFE0
//   column-nibble frame    : 4 * 0x111 * 28    mod 2^16 = 0x7770

module tb_vga_timing_decoder;

  localparam int HV = 8;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HT = 20;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VV = 4;
  localparam int VT = 12;
  localparam int H0 = HS + HB;
  localparam int V0 = VS + VB;

  logic        SYS_CLK;
  logic        reset;
  logic        hsync_i;
  logic        vsync_i;
  logic [3:0]  red_i, green_i, blue_i;
  logic        pix_valid_o;
  logic [11:0] rgb_o;
  logic [8:0]  row_o;
  logic [9:0]  column_o;
  logic        locked_o;
  logic        frame_done_o;
  logic [15:0] frame_sum_o;
  logic        err_hsync_o, err_line_o, err_frame_o;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Monitor state, written only by the monitor process.
  int          done_cnt  = 0;
  int          gap_cnt   = 0;
  int          frame_pix = 0;
  logic [8:0]  first_row, last_row;
  logic [9:0]  first_col, last_col;
  logic [11:0] last_rgb;
  time         first_t   = 0;

  // Written only by the stimulus process.
  time         t_pin     = 0;

  vga_timing_decoder #(
    .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_TOTAL(VT)
  ) dut (
    .SYS_CLK      (SYS_CLK),
    .reset        (reset),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .red_i        (red_i),
    .green_i      (green_i),
    .blue_i       (blue_i),
    .pix_valid_o  (pix_valid_o),
    .rgb_o        (rgb_o),
    .row_o        (row_o),
    .column_o     (column_o),
    .locked_o     (locked_o),
    .frame_done_o (frame_done_o),
    .frame_sum_o  (frame_sum_o),
    .err_hsync_o  (err_hsync_o),
    .err_line_o   (err_line_o),
    .err_frame_o  (err_frame_o)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  // Count frame_done pulses. Capture the first and last pixel of each frame;
  // a frame starts after a pixel gap longer than one line.
  always @(negedge SYS_CLK) begin
    if (frame_done_o) done_cnt <= done_cnt + 1;
    if (pix_valid_o) begin
      gap_cnt  <= 0;
      last_row <= row_o;
      last_col <= column_o;
      last_rgb <= rgb_o;
      if (gap_cnt > HT) begin
        first_row <= row_o;
        first_col <= column_o;
        first_t   <= $time;
        frame_pix <= 1;
      end else begin
        frame_pix <= frame_pix + 1;
      end
    end else begin
      gap_cnt <= gap_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one line: the hsync is low for hsw clocks, then the line runs to len clocks.
  task automatic drive_line(input int len, input int hsw, input bit vs_low,
                            input bit col_mode, input int line);
    logic [3:0] nib;
    for (int p = 0; p < len; p++) begin
      @(negedge SYS_CLK);
      hsync_i = (p < hsw) ? 1'b0 : 1'b1;
      vsync_i = ~vs_low;
      if (col_mode) begin
        nib = (p >= H0 && p < H0 + HV) ? 4'(p - H0) : 4'd0;
        {red_i, green_i, blue_i} = {nib, nib, nib};
      end else begin
        {red_i, green_i, blue_i} = 12'hFFF;
      end
      if (line == V0 && p == H0) t_pin = $time;
    end
  endtask

  task automatic drive_frame(input int nlines, input bit col_mode, input int bad_line,
                             input int bad_len, input int bad_hsw);
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == bad_line) ? bad_len : HT, (l == bad_line) ? bad_hsw : HS,
                 l < VS, col_mode, l);
    end
  endtask

  initial begin
    reset   = 1'b1;
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    {red_i, green_i, blue_i} = '0;
    repeat (3) @(negedge SYS_CLK);
    reset = 1'b0;

    // Reset state
    check("rst_pix_valid", pix_valid_o, 0);
    check("rst_rgb", rgb_o, 0);
    check("rst_row", row_o, 0);
    check("rst_col", column_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_sum", frame_sum_o, 0);
    check("rst_errs", {err_hsync_o, err_line_o, err_frame_o}, 0);

    // Frames 1-4: ideal timing with constant white pixels
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f1_acquire_not_locked", locked_o, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f2_locked", locked_o, 1);
    check("f2_no_done", done_cnt, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f3_done_cnt", done_cnt, 1);
    check("f3_sum_white", frame_sum_o, 32'hFFE0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f4_done_cnt", done_cnt, 2);
    check("f4_sum_white", frame_sum_o, 32'hFFE0);
    check("f4_no_errs", {err_hsync_o, err_line_o, err_frame_o}, 0);

    // Frame 5: column-nibble colour, check first/last pixel and latency
    drive_frame(VT, 1'b1, -1, 0, 0);
    check("f5_done_cnt", done_cnt, 3);
    check("f5_first_row", first_row, 0);
    check("f5_first_col", first_col, 0);
    check("f5_first_latency_ns", 32'(first_t - t_pin), 20);
    check("f5_last_row", last_row, VV - 1);
    check("f5_last_col", last_col, HV - 1);
    check("f5_last_rgb", last_rgb, 12'h777);
    check("f5_pixel_count", frame_pix, HV * VV);

    // Frame 6: line 6 one clock short
    drive_frame(VT, 1'b0, 6, HT - 1, HS);
    check("f6_done_cnt", done_cnt, 4);
    check("f6_sum_cols", frame_sum_o, 32'h7770);
    check("f6_err_line", err_line_o, 1);
    check("f6_unlocked", locked_o, 0);
    check("f6_err_hsync", err_hsync_o, 0);
    check("f6_err_frame", err_frame_o, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f7_not_locked", locked_o, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f8_relocked", locked_o, 1);
    check("f8_err_line_sticky", err_line_o, 1);
    check("f8_done_cnt", done_cnt, 4);

    // Frame 9: reset pulse in the middle of a visible line
    for (int l = 0; l < 6; l++) drive_line(HT, HS, l < VS, 1'b0, l);
    drive_line(10, HS, 1'b0, 1'b0, 6);
    check("f9_done_cnt", done_cnt, 5);
    check("f9_pre_pix_valid", pix_valid_o, 1);
    check("f9_pre_row", row_o, 1);
    check("f9_pre_col", column_o, 0);
    check("f9_pre_rgb", rgb_o, 12'hFFF);
    @(negedge SYS_CLK);
    reset = 1'b1;
    @(negedge SYS_CLK);
    reset = 1'b0;
    check("f9_rst_pix_valid", pix_valid_o, 0);
    check("f9_rst_rgb", rgb_o, 0);
    check("f9_rst_row_col", {row_o, column_o}, 0);
    check("f9_rst_locked", locked_o, 0);
    check("f9_rst_err_line", err_line_o, 0);
    check("f9_rst_sum", frame_sum_o, 0);
    for (int l = 7; l < VT; l++) drive_line(HT, HS, 1'b0, 1'b0, l);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f10_not_locked", locked_o, 0);
    check("f10_done_cnt", done_cnt, 5);
    drive_frame(VT, 1'b1, -1, 0, 0);
    check("f11_locked", locked_o, 1);
    check("f11_done_cnt", done_cnt, 5);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f12_done_cnt", done_cnt, 6);
    check("f12_sum_cols", frame_sum_o, 32'h7770);

    // Frame 13: short hsync while locked
    drive_frame(VT, 1'b0, 3, HT, HS - 1);
    check("f13_done_cnt", done_cnt, 7);
    check("f13_sum_white", frame_sum_o, 32'hFFE0);
    check("f13_err_hsync", err_hsync_o, 1);
    check("f13_unlocked", locked_o, 0);
    check("f13_err_line", err_line_o, 0);
    check("f13_err_frame", err_frame_o, 0);

    // Short hsync during ACQUIRE: back to HUNT, no flag
    @(negedge SYS_CLK);
    reset = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    reset = 1'b0;
    check("rst2_err_hsync", err_hsync_o, 0);
    drive_frame(VT, 1'b0, 3, HT, HS - 1);
    check("f14_not_locked", locked_o, 0);
    check("f14_err_hsync", err_hsync_o, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f15_rehunted_not_locked", locked_o, 0);

    // Frame 16: one line short in the frame while locked
    drive_frame(VT - 1, 1'b0, -1, 0, 0);
    check("f16_locked", locked_o, 1);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f17_err_frame", err_frame_o, 1);
    check("f17_unlocked", locked_o, 0);
    check("f17_done_suppressed", done_cnt, 7);
    check("f17_sum_kept", frame_sum_o, 0);

    // Relock, then hold the hsync high past counter saturation
    drive_frame(VT, 1'b0, -1, 0, 0);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f19_locked", locked_o, 1);
    drive_frame(VT, 1'b0, -1, 0, 0);
    check("f20_done_cnt", done_cnt, 8);
    check("f20_sum_white", frame_sum_o, 32'hFFE0);
    check("f20_err_line", err_line_o, 0);
    for (int l = 0; l < 3; l++) drive_line(HT, HS, l < VS, 1'b0, l);
    drive_line(2060, HS, 1'b0, 1'b0, 3);
    check("hold_err_line", err_line_o, 1);
    check("hold_unlocked", locked_o, 0);
    check("hold_err_hsync", err_hsync_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
